// File: rtl/demux3_route16b_pkg.sv
// Shared definitions for the 1-to-3 16-bit router: destination encoding,
// per-slot state type and default sizes.
package demux3_route16b_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 8;
    localparam int N_CH      = 3;

    // Same encoding as the select lines of the 3-input datapath mux.
    localparam logic [1:0] DEST_OUT1 = 2'd0;
    localparam logic [1:0] DEST_OUT2 = 2'd1;
    localparam logic [1:0] DEST_OUT3 = 2'd2;
    localparam logic [1:0] DEST_NONE = 2'd3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic dest_is_legal(input logic [1:0] dest);
        return dest != DEST_NONE;
    endfunction

endpackage

// File: rtl/demux3_route16b_if.sv
// Bus bundle for the router: one producer-side word port and three
// consumer-side channels.
interface demux3_route16b_if #(
    parameter int WIDTH = 16
) ();

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1. A producer holding valid may change data only after a transfer;
    // ready may depend combinationally on the consumer's own ready input.
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_dest;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;

    modport master (
        output in_data, in_dest, in_valid, out_ready,
        input  in_ready, out1_data, out2_data, out3_data, out_valid
    );

    modport slave (
        input  in_data, in_dest, in_valid, out_ready,
        output in_ready, out1_data, out2_data, out3_data, out_valid
    );

endinterface

// File: rtl/demux3_route16b_demux_slot.sv
// One output channel of the router: a single-entry holding register with a
// two-state EMPTY/FULL FSM and a saturating delivered-word counter.
module demux_slot
    import demux3_route16b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             can_accept_o,
    output logic [CNT_W-1:0] cnt_o,
    output slot_state_e      state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;

    assign fire = (state_q == SLOT_FULL) && ready_i;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        // A load in the same cycle as a drain keeps the slot FULL.
        case (state_q)
            SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
            SLOT_FULL:  if (fire && !load_i) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase

        if (load_i) data_d = data_i;

        if (clear_i) begin
            cnt_d = '0;
        end else if (fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = (state_q == SLOT_FULL);
    assign can_accept_o = (state_q == SLOT_EMPTY) || ready_i;
    assign cnt_o        = cnt_q;
    assign state_o      = state_q;

endmodule

// File: rtl/demux3_route16b.sv
// Registered 1-to-3 router between the result bus and the three write-back
// consumers; illegal destination words are accepted and dropped.
module demux3_route16b
    import demux3_route16b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    demux3_route16b_if.slave bus,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic             drop_err,
    output logic [2:0]       slot_state_dbg
);

    logic [1:0]       dest;
    logic             in_ready;
    logic [2:0]       can_accept;
    logic [2:0]       load;
    logic [2:0]       valid;
    logic [WIDTH-1:0] slot_data [N_CH];
    logic [CNT_W-1:0] slot_cnt  [N_CH];
    slot_state_e      slot_state[N_CH];
    logic             drop_q, drop_d;

    assign dest = bus.in_dest;

    // Only words aimed at a blocked slot are stalled; other channels keep flowing.
    always_comb begin
        in_ready = 1'b1;
        case (dest)
            DEST_OUT1: in_ready = can_accept[0];
            DEST_OUT2: in_ready = can_accept[1];
            DEST_OUT3: in_ready = can_accept[2];
            default:   in_ready = 1'b1;
        endcase
    end

    assign drop_d = bus.in_valid && in_ready && !dest_is_legal(dest);

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        assign load[g] = bus.in_valid && in_ready && (dest == 2'(g));

        demux_slot #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_slot (
            .clock_i     (clock),
            .reset_n_i   (reset_n),
            .load_i      (load[g]),
            .data_i      (bus.in_data),
            .ready_i     (bus.out_ready[g]),
            .clear_i     (cnt_clear),
            .data_o      (slot_data[g]),
            .valid_o     (valid[g]),
            .can_accept_o(can_accept[g]),
            .cnt_o       (slot_cnt[g]),
            .state_o     (slot_state[g])
        );

        assign slot_state_dbg[g] = (slot_state[g] == SLOT_FULL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.out1_data = slot_data[0];
    assign bus.out2_data = slot_data[1];
    assign bus.out3_data = slot_data[2];
    assign cnt1          = slot_cnt[0];
    assign cnt2          = slot_cnt[1];
    assign cnt3          = slot_cnt[2];
    assign drop_err      = drop_q;

endmodule

// File: tb/tb_demux3_route16b.sv
// Self-checking bench for demux3_route16b: cycle model plus per-channel
// expected-word queues, with directed checks for the named scenarios.
module tb_demux3_route16b;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cnt_clear;
    logic [7:0] cnt1, cnt2, cnt3;
    logic       drop_err;
    logic [2:0] slot_state_dbg;

    demux3_route16b_if #(.WIDTH(16)) bus ();

    demux3_route16b #(.WIDTH(16), .CNT_W(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bus),
        .cnt_clear     (cnt_clear),
        .cnt1          (cnt1),
        .cnt2          (cnt2),
        .cnt3          (cnt3),
        .drop_err      (drop_err),
        .slot_state_dbg(slot_state_dbg)
    );

    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];
    logic [15:0] exp_q3[$];
    logic [2:0]  exp_valid;
    logic [7:0]  exp_cnt [3];
    logic        exp_drop;
    int          n_vec = 0;
    int          n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return exp_q1.size();
            1:       return exp_q2.size();
            default: return exp_q3.size();
        endcase
    endfunction

    function automatic logic [15:0] q_front(input int k);
        case (k)
            0:       return exp_q1[0];
            1:       return exp_q2[0];
            default: return exp_q3[0];
        endcase
    endfunction

    task automatic q_pop(input int k);
        case (k)
            0:       void'(exp_q1.pop_front());
            1:       void'(exp_q2.pop_front());
            default: void'(exp_q3.pop_front());
        endcase
    endtask

    task automatic q_push(input int k, input logic [15:0] v);
        case (k)
            0:       exp_q1.push_back(v);
            1:       exp_q2.push_back(v);
            default: exp_q3.push_back(v);
        endcase
    endtask

    function automatic logic [15:0] out_data(input int k);
        case (k)
            0:       return bus.out1_data;
            1:       return bus.out2_data;
            default: return bus.out3_data;
        endcase
    endfunction

    function automatic logic [7:0] out_cnt(input int k);
        case (k)
            0:       return cnt1;
            1:       return cnt2;
            default: return cnt3;
        endcase
    endfunction

    // ---------------- monitor / model, sampled mid-cycle ----------------
    always @(negedge clock) begin
        logic       exp_rdy;
        logic [2:0] fire;
        logic [2:0] load;
        int         d;
        if (!reset_n) begin
            exp_q1.delete();
            exp_q2.delete();
            exp_q3.delete();
            exp_valid = 3'b000;
            for (int k = 0; k < 3; k++) exp_cnt[k] = 8'd0;
            exp_drop = 1'b0;
        end else begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("dbg_state", 32'(slot_state_dbg), 32'(exp_valid));
            check("drop_err", 32'(drop_err), 32'(exp_drop));
            for (int k = 0; k < 3; k++) begin
                check($sformatf("cnt%0d", k + 1), 32'(out_cnt(k)), 32'(exp_cnt[k]));
                if (exp_valid[k] && q_size(k) > 0)
                    check($sformatf("out%0d_data", k + 1), 32'(out_data(k)), 32'(q_front(k)));
            end

            d = int'(bus.in_dest);
            exp_rdy = (d == 3) ? 1'b1 : (!exp_valid[d] || bus.out_ready[d]);
            if (bus.in_valid) check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));

            fire = exp_valid & bus.out_ready;
            load = 3'b000;
            if (bus.in_valid && exp_rdy && d != 3) load[d] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (fire[k] && q_size(k) > 0) q_pop(k);
                if (cnt_clear) exp_cnt[k] = 8'd0;
                else if (fire[k] && exp_cnt[k] != 8'hFF) exp_cnt[k] = exp_cnt[k] + 8'd1;
                if (load[k]) q_push(k, bus.in_data);
            end
            exp_valid = (exp_valid & ~fire) | load;
            exp_drop  = bus.in_valid && (d == 3);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] data, input logic [1:0] dest);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_dest  = dest;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'(($urandom_range(0, 65535)));
        bus.in_dest  = 2'($urandom_range(0, 3));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        cnt_clear     = 1'b0;
        bus.out_ready = 3'b000;
        idle();
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_cnt3", 32'(cnt3), 32'h0);
        reset_n = 1'b1;
        step();

        // routing
        bus.out_ready = 3'b111;
        drive(16'h1111, 2'd0);
        step();
        drive(16'h2222, 2'd1);
        @(negedge clock);
        check("route_v1", 32'(bus.out_valid), 32'b001);
        check("route_d1", 32'(bus.out1_data), 32'h1111);
        step();
        drive(16'h3333, 2'd2);
        @(negedge clock);
        check("route_v2", 32'(bus.out_valid), 32'b010);
        check("route_d2", 32'(bus.out2_data), 32'h2222);
        step();
        idle();
        @(negedge clock);
        check("route_v3", 32'(bus.out_valid), 32'b100);
        check("route_d3", 32'(bus.out3_data), 32'h3333);
        step();
        @(negedge clock);
        check("route_cnt1", 32'(cnt1), 32'd1);
        check("route_cnt2", 32'(cnt2), 32'd1);
        check("route_cnt3", 32'(cnt3), 32'd1);

        // backpressure on channel 1, channel 2 keeps flowing
        step();
        bus.out_ready = 3'b110;
        drive(16'hAAAA, 2'd0);
        step();
        drive(16'hBBBB, 2'd0);
        @(negedge clock);
        check("bp_rdy_blocked", 32'(bus.in_ready), 32'd0);
        check("bp_hold1", 32'(bus.out1_data), 32'hAAAA);
        step();
        drive(16'hCCCC, 2'd1);
        @(negedge clock);
        check("bp_rdy_other", 32'(bus.in_ready), 32'd1);
        step();
        idle();
        @(negedge clock);
        check("bp_out2", 32'(bus.out2_data), 32'hCCCC);
        check("bp_hold2", 32'(bus.out1_data), 32'hAAAA);
        check("bp_v1", 32'(bus.out_valid[0]), 32'd1);
        step();
        bus.out_ready = 3'b111;
        step();

        // drain + fill in the same cycle
        bus.out_ready = 3'b110;
        drive(16'h0001, 2'd0);
        step();
        drive(16'h0002, 2'd0);
        bus.out_ready = 3'b111;
        @(negedge clock);
        check("df_rdy", 32'(bus.in_ready), 32'd1);
        step();
        idle();
        @(negedge clock);
        check("df_v1", 32'(bus.out_valid[0]), 32'd1);
        check("df_d1", 32'(bus.out1_data), 32'h0002);
        step();
        @(negedge clock);
        check("df_cnt1", 32'(cnt1), 32'd4);
        check("df_keep", 32'(bus.out1_data), 32'h0002);

        // illegal destination
        step();
        drive(16'hDEAD, 2'd3);
        @(negedge clock);
        check("ill_rdy", 32'(bus.in_ready), 32'd1);
        step();
        idle();
        @(negedge clock);
        check("ill_drop", 32'(drop_err), 32'd1);
        check("ill_valid", 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clock);
        check("ill_drop_end", 32'(drop_err), 32'd0);
        step();
        drive(16'hDEAD, 2'd3);
        step();
        drive(16'hBEEF, 2'd3);
        @(negedge clock);
        check("ill2_drop_a", 32'(drop_err), 32'd1);
        step();
        idle();
        @(negedge clock);
        check("ill2_drop_b", 32'(drop_err), 32'd1);
        step();
        @(negedge clock);
        check("ill2_drop_end", 32'(drop_err), 32'd0);

        // counter saturation and clear priority
        bus.out_ready = 3'b111;
        for (int i = 0; i < 260; i++) begin
            drive(16'(i), 2'd2);
            step();
        end
        idle();
        step();
        step();
        @(negedge clock);
        check("sat_cnt3", 32'(cnt3), 32'd255);
        bus.out_ready = 3'b011;
        drive(16'h5555, 2'd2);
        step();
        idle();
        bus.out_ready = 3'b111;
        cnt_clear     = 1'b1;
        @(negedge clock);
        check("clr_v3", 32'(bus.out_valid[2]), 32'd1);
        step();
        cnt_clear = 1'b0;
        @(negedge clock);
        check("clr_cnt3", 32'(cnt3), 32'd0);
        check("clr_cnt1", 32'(cnt1), 32'd0);

        // async reset with all slots full and drop_err high
        step();
        bus.out_ready = 3'b000;
        drive(16'h0007, 2'd0);
        step();
        drive(16'h0008, 2'd1);
        step();
        drive(16'h0009, 2'd2);
        step();
        drive(16'hDEAD, 2'd3);
        @(negedge clock);
        check("pre_rst_valid", 32'(bus.out_valid), 32'b111);
        step();
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_drop", 32'(drop_err), 32'd0);
        check("arst_cnt1", 32'(cnt1), 32'd0);
        check("arst_cnt2", 32'(cnt2), 32'd0);
        check("arst_d1", 32'(bus.out1_data), 32'd0);
        check("arst_d3", 32'(bus.out3_data), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // random traffic after reset, then drain everything
        for (int i = 0; i < 200; i++) begin
            bus.out_ready = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) drive(16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)));
            else idle();
            step();
        end
        idle();
        bus.out_ready = 3'b111;
        repeat (3) step();
        @(negedge clock);
        check("sb_empty", 32'(exp_q1.size() + exp_q2.size() + exp_q3.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
